multi_channel_p2s: RTL and testbench
====================================

MULTI_CHANNEL_P2S -- requirements
Module: multi_channel_p2s

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the bit width of each channel word and of the status word.
REQ-002 The block SHALL have parameter NUM_CH, default 3, meaning the number of filter channels; legal range is 1..DATA_W-1.
REQ-003 The block SHALL have the following ports, in this order:
- clk  input  1  system clock; the block's only clock.
- reset  input  1  asynchronous, active-high reset.
- filtered_data  input  NUM_CH*DATA_W  packed channel words; channel 0 occupies the LSBs.
- filter_done  input  NUM_CH  per-channel single-cycle strobe: new word is valid.
- rpi_sck  input  1  SPI clock from RP2350, asynchronous to clk, at most clk/8.
- rpi_cs  input  1  SPI chip select, active low, asynchronous to clk.
- rpi_miso  output  1  serial data, MSB first, idle high.
- overflow  output  1  sticky flag: at least one unread word was overwritten.

Function
REQ-004 The block SHALL synchronise rpi_sck and rpi_cs with 2-FF synchronisers and detect their edges in the clk domain.
REQ-005 Each channel SHALL hold one word in a holding register plus a valid flag.
REQ-006 filter_done[i] SHALL load filtered_data word i into hold[i] and set valid[i] on the next clk edge.
REQ-007 A filter_done[i] arriving while valid[i]=1 SHALL still overwrite hold[i] and SHALL set overflow.
REQ-008 The FSM SHALL have three states:
- IDLE -> LOAD on a synchronised CS falling edge.
- LOAD -> SHIFT after 1 cycle.
- SHIFT -> IDLE when CS rises or when the frame completes.
REQ-009 In LOAD, the block SHALL snapshot the frame into a shift register of (NUM_CH+1)*DATA_W bits.
- The frame is the status word followed by channel 0..NUM_CH-1.
- It SHALL also snapshot the valid mask into snap_mask.
REQ-010 Status word layout:
- bit DATA_W-1 = overflow.
- bits NUM_CH-1:0 = valid mask.
- all other bits 0.
REQ-011 A channel whose valid flag is 0 at snapshot SHALL send all-ones (16'hFFFF at default) in place of its word.
REQ-012 rpi_miso SHALL equal the shift-register MSB in LOAD and SHIFT, and 1 otherwise.
REQ-013 The first frame bit SHALL appear on rpi_miso no later than 4 clk cycles after the raw rpi_cs falls.
REQ-014 In SHIFT, each synchronised rpi_sck falling edge SHALL shift the register left by one, fill with 1, and increment the bit counter.
- Counter width is clog2((NUM_CH+1)*DATA_W)+1.
REQ-015 Shifting after the last frame bit SHALL continue to fill 1s, so rpi_miso stays high.
REQ-016 When the counter reaches (NUM_CH+1)*DATA_W, the frame is complete.
- The block SHALL clear valid[i] for every i with snap_mask[i]=1, unless filter_done[i] occurred after the snapshot.
- The block SHALL clear overflow, unless a new overflow occurred after the snapshot.
REQ-017 On a complete frame, a filter_done[i] coinciding with the clearing cycle SHALL win: valid[i] ends at 1.
REQ-018 If CS rises before frame completion (abort), the block SHALL leave all valid flags and overflow unchanged, so the data is resent in the next frame.
REQ-019 A CS falling edge seen outside IDLE SHALL be ignored.
REQ-020 filter_done SHALL be accepted in every FSM state without loss.

Reset
REQ-021 While reset is high, the block SHALL hold these values:
- FSM in IDLE.
- all valid flags 0, overflow 0.
- holding registers 0, shift register all ones, bit counter 0.
- rpi_miso 1.
- CS synchroniser stages 1, SCK synchroniser stages 0.
REQ-022 Reset asserted mid-frame SHALL immediately force rpi_miso high and discard the frame.
REQ-023 After reset deasserts, the first CS falling edge SHALL be detected only from synchronised samples taken after reset.

Structure
REQ-024 Package kf_spi_pkg SHALL define the shared items:
- default DATA_W and NUM_CH.
- the FSM state enum.
- status-word bit positions: overflow at DATA_W-1, mask base 0.
- the all-ones idle word.
REQ-025 The 2-FF synchroniser SHALL be a separate sub-module sync_2ff with a reset-value parameter, instantiated twice.

Verification
REQ-026 The bench SHALL cover these directed scenarios (default parameters):
- Basic frame: strobe ch0=16'h1234, ch1=16'hABCD, ch2=16'h0F0F, then a full 64-bit frame -> MISO reads 16'h0007,1234,ABCD,0F0F; all valid flags clear.
- Missing data: only ch1=16'h5555 strobed -> frame reads 16'h0002,FFFF,5555,FFFF; an immediate second frame reads 16'h0000,FFFF,FFFF,FFFF.
- Overflow: ch0 strobed with 16'h1111 then 16'h2222 with no read between -> status 16'h8001, ch0=2222; overflow clears after the frame.
- Abort: CS raised after 20 SCK edges -> valid flags unchanged; the next full frame re-sends identical data.
- Simultaneous event: filter_done[2] with 16'h7777 during SHIFT and on the completion cycle -> valid[2]=1 after the frame; the next frame carries 7777.
- Reset mid-frame: reset pulse after 30 SCK edges -> MISO=1, all flags 0; the next frame status is 16'h0000.

Source files
------------

// File: rtl/kf_spi_pkg.sv
// Shared types and constants for the multi-channel parallel-to-serial SPI bridge.
package kf_spi_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NUM_CH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  // Status word: overflow in the top bit, valid mask starting at bit 0.
  localparam int MASK_BASE = 0;

  localparam logic                  IDLE_BIT  = 1'b1;
  localparam logic [DEF_DATA_W-1:0] IDLE_WORD = {DEF_DATA_W{IDLE_BIT}};

  function automatic int ovf_bit(input int data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/multi_channel_p2s.sv
// Latches per-channel filter words and serialises a status+channel frame to an SPI master
// (RP2350) whose SCK/CS are oversampled in the clk domain.
module multi_channel_p2s
  import kf_spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] filtered_data,
  input  logic [NUM_CH-1:0]        filter_done,
  input  logic                     rpi_sck,
  input  logic                     rpi_cs,
  output logic                     rpi_miso,
  output logic                     overflow
);

  localparam int FRAME_W = (NUM_CH + 1) * DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W) + 1;
  localparam int OVF_BIT = ovf_bit(DATA_W);
  localparam logic [DATA_W-1:0] FILL_WORD = {DATA_W{IDLE_BIT}};

  logic cs_s, sck_s;

  sync_2ff #(.RST_VAL(1'b1)) u_cs_sync  (.clk(clk), .reset(reset), .d(rpi_cs),  .q(cs_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sck_sync (.clk(clk), .reset(reset), .d(rpi_sck), .q(sck_s));

  state_e               state_q, state_d;
  logic                 cs_prev_q, cs_prev_d;
  logic                 sck_prev_q, sck_prev_d;
  logic [DATA_W-1:0]    hold_q [NUM_CH];
  logic [DATA_W-1:0]    hold_d [NUM_CH];
  logic [NUM_CH-1:0]    valid_q, valid_d;
  logic [NUM_CH-1:0]    snap_mask_q, snap_mask_d;
  logic [NUM_CH-1:0]    done_since_q, done_since_d;
  logic                 overflow_q, overflow_d;
  logic                 ovf_since_q, ovf_since_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 cs_fall, sck_fall, snap, frame_done, ovf_event;
  logic [NUM_CH-1:0]    clr_mask, valid_kept;
  logic [DATA_W-1:0]    status;
  logic [FRAME_W-1:0]   frame;

  // Frame image built from the current holding registers; captured on entry to LOAD.
  always_comb begin
    status = '0;
    status[OVF_BIT] = overflow_q;
    status[MASK_BASE +: NUM_CH] = valid_q;
    frame = '0;
    frame[FRAME_W-1 -: DATA_W] = status;
    for (int i = 0; i < NUM_CH; i++) begin
      frame[FRAME_W-1-(i+1)*DATA_W -: DATA_W] = valid_q[i] ? hold_q[i] : FILL_WORD;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    snap_mask_d = snap_mask_q;
    hold_d      = hold_q;
    cs_prev_d   = cs_s;
    sck_prev_d  = sck_s;
    cs_fall     = cs_prev_q & ~cs_s;
    sck_fall    = sck_prev_q & ~sck_s;
    snap        = 1'b0;
    frame_done  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_LOAD;
          shift_d     = frame;
          cnt_d       = '0;
          snap_mask_d = valid_q;
          snap        = 1'b1;
        end
      end
      ST_LOAD: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (cs_s) begin
          state_d = ST_IDLE;
        end else if (sck_fall) begin
          shift_d = {shift_q[FRAME_W-2:0], 1'b1};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(FRAME_W)) begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Words strobed after the snapshot survive the end-of-frame clear; a strobe on the
    // clear cycle itself wins as well.
    clr_mask     = frame_done ? (snap_mask_q & ~done_since_q) : '0;
    valid_kept   = valid_q & ~clr_mask;
    ovf_event    = |(filter_done & valid_kept);
    valid_d      = valid_kept | filter_done;
    overflow_d   = (overflow_q & ~(frame_done & ~ovf_since_q)) | ovf_event;
    done_since_d = snap ? filter_done : (done_since_q | filter_done);
    ovf_since_d  = snap ? ovf_event   : (ovf_since_q | ovf_event);

    for (int i = 0; i < NUM_CH; i++) begin
      if (filter_done[i]) hold_d[i] = filtered_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cs_prev_q    <= 1'b1;
      sck_prev_q   <= 1'b0;
      valid_q      <= '0;
      snap_mask_q  <= '0;
      done_since_q <= '0;
      overflow_q   <= 1'b0;
      ovf_since_q  <= 1'b0;
      shift_q      <= '1;
      cnt_q        <= '0;
      // NOTE: the holding array is only NUM_CH words, so it is reset like any other register.
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cs_prev_q    <= cs_prev_d;
      sck_prev_q   <= sck_prev_d;
      valid_q      <= valid_d;
      snap_mask_q  <= snap_mask_d;
      done_since_q <= done_since_d;
      overflow_q   <= overflow_d;
      ovf_since_q  <= ovf_since_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
    end
  end

  assign rpi_miso = (state_q == ST_IDLE) ? 1'b1 : shift_q[FRAME_W-1];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_multi_channel_p2s.sv
// Directed bench for multi_channel_p2s: an SPI master model reads 64-bit frames
// and each scenario task compares them against hand-computed frame images.
module tb_multi_channel_p2s;
  import kf_spi_pkg::*;

  localparam int DW = 16;
  localparam int NC = 3;
  localparam logic [15:0] F = IDLE_WORD;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NC*DW-1:0] filtered_data = '0;
  logic [NC-1:0]   filter_done = '0;
  logic            rpi_sck = 1'b0;
  logic            rpi_cs = 1'b1;
  logic            rpi_miso;
  logic            overflow;

  int n_assert = 0;
  int n_fail   = 0;

  multi_channel_p2s #(.DATA_W(DW), .NUM_CH(NC)) dut (
    .clk(clk), .reset(reset), .filtered_data(filtered_data), .filter_done(filter_done),
    .rpi_sck(rpi_sck), .rpi_cs(rpi_cs), .rpi_miso(rpi_miso), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input int ch, input logic [15:0] val);
    filtered_data[ch*DW +: DW] = val;
    filter_done = 3'b001 << ch;
    wait_clk(1);
    filter_done = '0;
  endtask

  // SPI master: MISO is sampled while SCK is high, the slave shifts on SCK falling.
  // stb_mid strobes ch2=7777 mid-frame; stb_end strobes it on the completion cycle.
  task automatic spi_frame(input int n_fall, input bit stb_mid, input bit stb_end,
                           output logic [63:0] data);
    data = '1;
    rpi_cs = 1'b0;
    wait_clk(6);
    for (int i = 0; i < n_fall; i++) begin
      rpi_sck = 1'b1;
      wait_clk(6);
      if (i < 64) data[63-i] = rpi_miso;
      rpi_sck = 1'b0;
      if (stb_end && i == 63) begin
        wait_clk(2);
        strobe(2, 16'h7777);
        wait_clk(3);
      end else if (stb_mid && i == 10) begin
        strobe(2, 16'h7777);
        wait_clk(5);
      end else begin
        wait_clk(6);
      end
    end
    wait_clk(6);
    rpi_cs = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_reset;
    wait_clk(3);
    n_assert++;
    if (rpi_miso !== 1'b1) begin
      n_fail++; $display("FAIL reset_miso: got %b, required 1", rpi_miso);
    end
    n_assert++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow: got %b, required 0", overflow);
    end
    reset = 1'b0;
    wait_clk(5);
    n_assert++;
    if (rpi_miso !== 1'b1) begin
      n_fail++; $display("FAIL idle_miso: got %b, required 1", rpi_miso);
    end
  endtask

  task automatic test_basic_frame;
    logic [63:0] got;
    strobe(0, 16'h1234);
    strobe(1, 16'hABCD);
    strobe(2, 16'h0F0F);
    spi_frame(64, 0, 0, got);
    n_assert++;
    if (got !== 64'h0007_1234_ABCD_0F0F) begin
      n_fail++; $display("FAIL basic_frame: got %h, required %h", got, 64'h0007_1234_ABCD_0F0F);
    end
    spi_frame(64, 0, 0, got);
    n_assert++;
    if (got !== {16'h0000, F, F, F}) begin
      n_fail++; $display("FAIL basic_cleared: got %h, required %h", got, {16'h0000, F, F, F});
    end
  endtask

  task automatic test_missing_data;
    logic [63:0] got;
    strobe(1, 16'h5555);
    spi_frame(64, 0, 0, got);
    n_assert++;
    if (got !== {16'h0002, F, 16'h5555, F}) begin
      n_fail++; $display("FAIL missing_frame: got %h, required %h", got, {16'h0002, F, 16'h5555, F});
    end
    spi_frame(64, 0, 0, got);
    n_assert++;
    if (got !== {16'h0000, F, F, F}) begin
      n_fail++; $display("FAIL missing_second: got %h, required %h", got, {16'h0000, F, F, F});
    end
  endtask

  task automatic test_overflow;
    logic [63:0] got;
    strobe(0, 16'h1111);
    n_assert++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_first_write: got %b, required 0", overflow);
    end
    strobe(0, 16'h2222);
    n_assert++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got %b, required 1", overflow);
    end
    spi_frame(64, 0, 0, got);
    n_assert++;
    if (got !== {16'h8001, 16'h2222, F, F}) begin
      n_fail++; $display("FAIL ovf_frame: got %h, required %h", got, {16'h8001, 16'h2222, F, F});
    end
    n_assert++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_cleared: got %b, required 0", overflow);
    end
  endtask

  task automatic test_abort;
    logic [63:0] got;
    strobe(0, 16'hAAAA);
    strobe(2, 16'h0001);
    spi_frame(20, 0, 0, got);
    n_assert++;
    if (got[63:44] !== {16'h0005, 4'hA}) begin
      n_fail++; $display("FAIL abort_partial: got %h, required %h", got[63:44], {16'h0005, 4'hA});
    end
    spi_frame(64, 0, 0, got);
    n_assert++;
    if (got !== {16'h0005, 16'hAAAA, F, 16'h0001}) begin
      n_fail++; $display("FAIL abort_resend: got %h, required %h", got, {16'h0005, 16'hAAAA, F, 16'h0001});
    end
    spi_frame(64, 0, 0, got);
    n_assert++;
    if (got !== {16'h0000, F, F, F}) begin
      n_fail++; $display("FAIL abort_cleared: got %h, required %h", got, {16'h0000, F, F, F});
    end
  endtask

  task automatic test_simultaneous;
    logic [63:0] got;
    spi_frame(64, 1, 1, got);
    n_assert++;
    if (got !== {16'h0000, F, F, F}) begin
      n_fail++; $display("FAIL simul_frame: got %h, required %h", got, {16'h0000, F, F, F});
    end
    // The mid-frame word is unread when the completion-cycle strobe overwrites it.
    n_assert++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL simul_overflow: got %b, required 1", overflow);
    end
    spi_frame(64, 0, 0, got);
    n_assert++;
    if (got !== {16'h8004, F, F, 16'h7777}) begin
      n_fail++; $display("FAIL simul_next: got %h, required %h", got, {16'h8004, F, F, 16'h7777});
    end
    n_assert++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL simul_ovf_cleared: got %b, required 0", overflow);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [63:0] got;
    strobe(0, 16'h1357);
    strobe(1, 16'h2468);
    strobe(1, 16'h9999);
    rpi_cs = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 30; i++) begin
      rpi_sck = 1'b1;
      wait_clk(6);
      rpi_sck = 1'b0;
      wait_clk(6);
    end
    n_assert++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_overflow: got %b, required 1", overflow);
    end
    reset = 1'b1;
    #1;
    n_assert++;
    if (rpi_miso !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_miso: got %b, required 1", rpi_miso);
    end
    n_assert++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_overflow: got %b, required 0", overflow);
    end
    rpi_cs = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(5);
    spi_frame(64, 0, 0, got);
    n_assert++;
    if (got !== {16'h0000, F, F, F}) begin
      n_fail++; $display("FAIL rst_next_frame: got %h, required %h", got, {16'h0000, F, F, F});
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_missing_data();
    test_overflow();
    test_abort();
    test_simultaneous();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
